// File: rtl/kmeans_update_centroids.sv
// K-means recompute stage: scans assigned points, accumulates per-cluster sums/counts,
// divides with serial restoring dividers, writes new centroids back and flags movement.
module kmeans_update_centroids #(
  parameter int unsigned       MAX_CLUSTERS    = 8,
  parameter int unsigned       CNT_W           = 16,
  parameter int unsigned       ACC_W           = 16 + CNT_W,
  parameter int unsigned       ADDR_W          = 16,
  parameter logic [ADDR_W-1:0] POINT_LADDR     = 'h0100,
  parameter logic [ADDR_W-1:0] FCLUSTER_LADDR  = 'h0080,
  parameter logic [ADDR_W-1:0] FCENTROID_LADDR = 'h0000
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              changed_o,
  output logic              bad_id_o,
  input  logic [CNT_W-1:0]  num_vals_i,
  input  logic [7:0]        num_clusters_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_dout_o,
  input  logic [31:0]       mem_din_i
);

  localparam int unsigned IdxW    = (MAX_CLUSTERS > 1) ? $clog2(MAX_CLUSTERS) : 1;
  localparam int unsigned DivCntW = $clog2(ACC_W) + 1;

  typedef enum logic [3:0] {
    StIdle, StPtAddr, StIdAddr, StAccum, StOldAddr, StDivInit, StDivRun, StWrite, StDone
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    i_q;
  logic [7:0]          k_q;
  logic [31:0]         point_q, old_q;
  logic [ACC_W-1:0]    sum_a_q [MAX_CLUSTERS];
  logic [ACC_W-1:0]    sum_b_q [MAX_CLUSTERS];
  logic [CNT_W-1:0]    cnt_q   [MAX_CLUSTERS];
  logic [ACC_W-1:0]    rem_a_q, rem_b_q, quo_a_q, quo_b_q, dvs_q;
  logic [DivCntW-1:0]  div_cnt_q;
  logic                done_q, changed_q, bad_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_dout_q;

  logic [7:0]          nc;
  logic [7:0]          acc_id;
  logic [7:0]          k_nx;
  logic [CNT_W-1:0]    i_nx;
  logic [IdxW-1:0]     slot_k;
  logic [ACC_W-1:0]    rem_a_nx, rem_b_nx, quo_a_nx, quo_b_nx;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [2*ACC_W-1:0] div_step(input logic [ACC_W-1:0] rem,
                                                  input logic [ACC_W-1:0] quo,
                                                  input logic [ACC_W-1:0] dvs);
    logic [ACC_W:0] sh, diff;
    sh   = {rem, quo[ACC_W-1]};
    diff = sh - {1'b0, dvs};
    if (diff[ACC_W]) return {sh[ACC_W-1:0], quo[ACC_W-2:0], 1'b0};
    else             return {diff[ACC_W-1:0], quo[ACC_W-2:0], 1'b1};
  endfunction

  always_comb begin
    nc     = (num_clusters_i > 8'(MAX_CLUSTERS)) ? 8'(MAX_CLUSTERS) : num_clusters_i;
    acc_id = mem_din_i[{i_q[1:0], 3'b000} +: 8];
    k_nx   = k_q + 8'd1;
    i_nx   = i_q + CNT_W'(1);
    slot_k = k_q[IdxW-1:0];
    {rem_a_nx, quo_a_nx} = div_step(rem_a_q, quo_a_q, dvs_q);
    {rem_b_nx, quo_b_nx} = div_step(rem_b_q, quo_b_q, dvs_q);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      i_q        <= '0;
      k_q        <= '0;
      point_q    <= '0;
      old_q      <= '0;
      rem_a_q    <= '0;
      rem_b_q    <= '0;
      quo_a_q    <= '0;
      quo_b_q    <= '0;
      dvs_q      <= '0;
      div_cnt_q  <= '0;
      done_q     <= 1'b0;
      changed_q  <= 1'b0;
      bad_q      <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      for (int unsigned c = 0; c < MAX_CLUSTERS; c++) begin
        sum_a_q[c] <= '0;
        sum_b_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      mem_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            for (int unsigned c = 0; c < MAX_CLUSTERS; c++) begin
              sum_a_q[c] <= '0;
              sum_b_q[c] <= '0;
              cnt_q[c]   <= '0;
            end
            changed_q <= 1'b0;
            bad_q     <= 1'b0;
            i_q       <= '0;
            k_q       <= '0;
            if (num_vals_i != '0) begin
              state_q    <= StPtAddr;
              mem_addr_q <= POINT_LADDR;
            end else if (nc == 8'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StOldAddr;
              mem_addr_q <= FCENTROID_LADDR;
            end
          end
        end
        StPtAddr: begin
          mem_addr_q <= FCLUSTER_LADDR + ADDR_W'(i_q >> 2);
          state_q    <= StIdAddr;
        end
        StIdAddr: begin
          point_q <= mem_din_i;
          state_q <= StAccum;
        end
        StAccum: begin
          if (acc_id < nc) begin
            for (int unsigned c = 0; c < MAX_CLUSTERS; c++) begin
              if (acc_id == 8'(c)) begin
                sum_a_q[c] <= sum_a_q[c] + ACC_W'(point_q[31:16]);
                sum_b_q[c] <= sum_b_q[c] + ACC_W'(point_q[15:0]);
                cnt_q[c]   <= cnt_q[c] + CNT_W'(1);
              end
            end
          end else begin
            bad_q <= 1'b1;
          end
          i_q <= i_nx;
          if (i_q == num_vals_i - CNT_W'(1)) begin
            if (nc == 8'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StOldAddr;
              mem_addr_q <= FCENTROID_LADDR;
            end
          end else begin
            state_q    <= StPtAddr;
            mem_addr_q <= POINT_LADDR + ADDR_W'(i_nx);
          end
        end
        StOldAddr: state_q <= StDivInit;
        StDivInit: begin
          old_q <= mem_din_i;
          if (cnt_q[slot_k] == '0) begin
            mem_dout_q <= mem_din_i;
            mem_we_q   <= 1'b1;
            state_q    <= StWrite;
          end else begin
            rem_a_q   <= '0;
            rem_b_q   <= '0;
            quo_a_q   <= sum_a_q[slot_k];
            quo_b_q   <= sum_b_q[slot_k];
            dvs_q     <= ACC_W'(cnt_q[slot_k]);
            div_cnt_q <= '0;
            state_q   <= StDivRun;
          end
        end
        StDivRun: begin
          rem_a_q   <= rem_a_nx;
          rem_b_q   <= rem_b_nx;
          quo_a_q   <= quo_a_nx;
          quo_b_q   <= quo_b_nx;
          div_cnt_q <= div_cnt_q + DivCntW'(1);
          if (div_cnt_q == DivCntW'(ACC_W - 1)) begin
            mem_dout_q <= {quo_a_nx[15:0], quo_b_nx[15:0]};
            mem_we_q   <= 1'b1;
            state_q    <= StWrite;
          end
        end
        StWrite: begin
          if (mem_dout_q != old_q) changed_q <= 1'b1;
          k_q <= k_nx;
          if (k_nx == nc) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q    <= StOldAddr;
            mem_addr_q <= FCENTROID_LADDR + ADDR_W'(k_nx);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o    = (state_q == StIdle);
  assign done_o     = done_q;
  assign changed_o  = changed_q;
  assign bad_id_o   = bad_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_dout_o = mem_dout_q;

endmodule

// File: tb/tb_kmeans_update_centroids.sv
// Bench for kmeans_update_centroids: BRAM model, write monitor, and an arithmetic
// reference model of one recompute pass (means, change flag, bad-ID flag, latency).
module tb_kmeans_update_centroids;

  localparam int          AccW   = 32;
  localparam int          MaxPts = 64;
  localparam logic [15:0] PtBase = 16'h0100;
  localparam logic [15:0] IdBase = 16'h0080;
  localparam logic [15:0] CBase  = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        ready, done, changed, bad_id, mem_we;
  logic [15:0] num_vals = '0;
  logic [7:0]  num_clusters = '0;
  logic [15:0] mem_addr;
  logic [31:0] mem_dout, mem_din;

  kmeans_update_centroids dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .start_i        (start),
    .ready_o        (ready),
    .done_o         (done),
    .changed_o      (changed),
    .bad_id_o       (bad_id),
    .num_vals_i     (num_vals),
    .num_clusters_i (num_clusters),
    .mem_addr_o     (mem_addr),
    .mem_we_o       (mem_we),
    .mem_dout_o     (mem_dout),
    .mem_din_i      (mem_din)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge clk) mem_din <= mem[mem_addr];

  logic [47:0] wr_q[$];
  int          done_cnt;
  always @(negedge clk) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_dout});
    if (done) done_cnt++;
  end

  logic [31:0] pt_a  [MaxPts];
  logic [7:0]  id_a  [MaxPts];
  logic [31:0] old_c [8];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_mem(input int n);
    logic [31:0] word;
    for (int i = 0; i < n; i++) mem[PtBase + 16'(i)] = pt_a[i];
    for (int w = 0; w < (n + 3) / 4; w++) begin
      word = '0;
      for (int b = 0; b < 4; b++) if (4 * w + b < n) word[8*b +: 8] = id_a[4*w+b];
      mem[IdBase + 16'(w)] = word;
    end
    for (int k = 0; k < 8; k++) mem[CBase + 16'(k)] = old_c[k];
  endtask

  task automatic run_pass(input string tag, input int n, input int nc_in, input bit hold);
    longint      sa [8];
    longint      sb [8];
    longint      cn [8];
    logic [31:0] exp_w [8];
    logic [47:0] e;
    bit          exp_bad, exp_chg;
    int          nce, exp_lat, cyc;
    nce = (nc_in > 8) ? 8 : nc_in;
    exp_bad = 1'b0;
    exp_chg = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sa[k] = 0; sb[k] = 0; cn[k] = 0;
    end
    for (int i = 0; i < n; i++) begin
      if (int'(id_a[i]) < nce) begin
        sa[id_a[i]] += longint'(pt_a[i][31:16]);
        sb[id_a[i]] += longint'(pt_a[i][15:0]);
        cn[id_a[i]] += 1;
      end else begin
        exp_bad = 1'b1;
      end
    end
    exp_lat = 3 * n + 1;
    for (int k = 0; k < nce; k++) begin
      if (cn[k] == 0) begin
        exp_w[k] = old_c[k];
        exp_lat += 3;
      end else begin
        exp_w[k] = {16'(sa[k] / cn[k]), 16'(sb[k] / cn[k])};
        exp_lat += 3 + AccW;
      end
      if (exp_w[k] != old_c[k]) exp_chg = 1'b1;
    end

    load_mem(n);
    wr_q.delete();
    done_cnt = 0;
    num_vals = 16'(n);
    num_clusters = 8'(nc_in);
    @(negedge clk);
    check({tag, ".ready_pre"}, 64'(ready), 64'd1);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    cyc = 1;
    while (!done && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, ".changed"}, 64'(changed), 64'(exp_chg));
    check({tag, ".bad_id"}, 64'(bad_id), 64'(exp_bad));
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".ready_post"}, 64'(ready), 64'd1);
    if (hold) begin
      repeat (5) @(posedge clk);
      #1;
      check({tag, ".no_relaunch"}, 64'(ready), 64'd1);
    end
    check({tag, ".ndone"}, 64'(done_cnt), 64'd1);
    check({tag, ".nwrites"}, 64'(wr_q.size()), 64'(nce));
    for (int k = 0; k < nce && k < wr_q.size(); k++) begin
      e = {CBase + 16'(k), exp_w[k]};
      check($sformatf("%s.write%0d", tag, k), 64'(wr_q[k]), 64'(e));
    end
  endtask

  task automatic set_directed();
    pt_a[0] = 32'h01000200; id_a[0] = 8'd0;
    pt_a[1] = 32'h03000400; id_a[1] = 8'd0;
    pt_a[2] = 32'h0A000000; id_a[2] = 8'd1;
    for (int k = 0; k < 8; k++) old_c[k] = '0;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check("rst.ready", 64'(ready), 64'd1);
    check("rst.done", 64'(done), 64'd0);
    check("rst.changed", 64'(changed), 64'd0);
    check("rst.bad_id", 64'(bad_id), 64'd0);
    check("rst.we", 64'(mem_we), 64'd0);
    check("rst.addr", 64'(mem_addr), 64'd0);
    check("rst.dout", 64'(mem_dout), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    set_directed();
    run_pass("directed", 3, 2, 1'b0);
    old_c[0] = 32'h02000300;
    old_c[1] = 32'h0A000000;
    run_pass("converged", 3, 2, 1'b0);

    pt_a[0] = 32'h00010001; id_a[0] = 8'd0;
    pt_a[1] = 32'h00020002; id_a[1] = 8'd0;
    old_c[0] = '0;
    run_pass("trunc", 2, 1, 1'b0);

    set_directed();
    old_c[0] = 32'h02000300;
    old_c[1] = 32'h0A000000;
    old_c[2] = 32'h12345678;
    run_pass("empty", 3, 3, 1'b0);

    pt_a[3] = 32'h7F007F00; id_a[3] = 8'd5;
    run_pass("badid", 4, 2, 1'b0);
    run_pass("nc0", 3, 0, 1'b0);
    run_pass("nv0", 0, 2, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int n, nc, lim;
      n = int'($urandom_range(0, 24));
      nc = int'($urandom_range(0, 10));
      lim = (nc > 8) ? 8 : nc;
      for (int i = 0; i < n; i++) begin
        pt_a[i] = $urandom;
        if ($urandom_range(0, 4) == 0 || lim == 0) id_a[i] = 8'($urandom_range(0, 255));
        else id_a[i] = 8'($urandom_range(0, lim - 1));
      end
      for (int k = 0; k < 8; k++) old_c[k] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      run_pass($sformatf("rand%0d", r), n, nc, 1'b0);
    end

    // Abort a pass while the first divider is running.
    set_directed();
    load_mem(3);
    num_vals = 16'd3;
    num_clusters = 8'd2;
    wr_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("abort.busy", 64'(ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("abort.ready", 64'(ready), 64'd1);
    check("abort.we", 64'(mem_we), 64'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("abort.nwrites", 64'(wr_q.size()), 64'd0);

    set_directed();
    run_pass("hold", 3, 2, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/kmeans_update_centroids.md
Name: kmeans_update_centroids

Overview:
Recompute stage of the k-means loop, directly downstream of the distance/assignment stage. Once every point has a cluster ID in the IO BRAM cluster region, this block:
- accumulates per-cluster coordinate sums and member counts,
- divides each sum by its count,
- writes the new centroids back to the centroid region,
- reports whether any centroid moved, so the controller can stop or iterate.

Parameters:
MAX_CLUSTERS, 8, number of accumulator slots; cluster IDs must be below this.
CNT_W, 16, width of point counter and per-cluster member counts.
ACC_W, 16+CNT_W, width of per-cluster coordinate sums and divider width.
ADDR_W, 16, IO BRAM word address width.
POINT_LADDR, 'h0100, word address of point 0.
FCLUSTER_LADDR, 'h0080, word address of packed cluster IDs.
FCENTROID_LADDR, 'h0000, word address of centroid 0.

Ports:
clk_i  in  1  clock; the only clock.
reset_ni  in  1  asynchronous, active-low reset.
start_i  in  1  start one recompute pass; sampled only in IDLE.
ready_o  out  1  high in IDLE.
done_o  out  1  one-cycle pulse when the pass completes.
changed_o  out  1  any centroid differs from its previous value; valid from done_o until next start.
bad_id_o  out  1  sticky for the pass; some point carried ID >= num_clusters.
num_vals_i  in  CNT_W  number of points; held stable during the pass.
num_clusters_i  in  8  number of active clusters; clamped to MAX_CLUSTERS.
mem_addr_o  out  ADDR_W  IO BRAM address.
mem_we_o  out  1  IO BRAM write enable.
mem_dout_o  out  32  IO BRAM write data.
mem_din_i  in  32  IO BRAM read data; valid one cycle after the address is presented.

Behaviour:
Data format and arithmetic:
- Data word: [31:16] = coordinate A, [15:0] = coordinate B; both unsigned Q8.8.
- Cluster ID of point i: byte (i mod 4), bits [8*(i%4)+:8], of word FCLUSTER_LADDR + (i>>2).
- Sums accumulate zero-extended to ACC_W. No overflow is possible for num_vals_i < 2^CNT_W.

Reset values:
- ready_o=1; done_o, changed_o, bad_id_o, mem_we_o = 0; mem_addr_o=0; mem_dout_o=0.
- FSM in IDLE; all sums and counts cleared.

FSM:
- IDLE: ready_o=1.
  - On start_i: clear sums, counts, changed_o, bad_id_o; set i=0, k=0; go PT_ADDR.
  - If num_vals_i=0, go straight to OLD_ADDR.
  - start_i outside IDLE is ignored.
- PT_ADDR: mem_addr_o=POINT_LADDR+i; go ID_ADDR.
- ID_ADDR: latch mem_din_i as the point; mem_addr_o=FCLUSTER_LADDR+(i>>2); go ACCUM.
- ACCUM: extract ID from mem_din_i.
  - If ID < num_clusters: sumA[ID]+=A, sumB[ID]+=B, cnt[ID]+=1.
  - Else: set bad_id_o and skip the point.
  - i+=1. If i = num_vals_i-1, go OLD_ADDR; else go PT_ADDR.
  - Cost: 3 cycles per point.
- OLD_ADDR: mem_addr_o=FCENTROID_LADDR+k; go DIV.
- DIV (first cycle): latch old centroid from mem_din_i.
  - If cnt[k]=0: new=old, skip to WRITE.
  - Else: run restoring dividers sumA/cnt and sumB/cnt in parallel, 1 quotient bit per cycle, ACC_W cycles.
  - Quotient is truncated (floor); the low 16 bits form the new coordinate. The mean never exceeds 0xFFFF.
- WRITE: mem_we_o=1 for exactly one cycle; mem_addr_o=FCENTROID_LADDR+k; mem_dout_o={newA,newB}.
  - If new != old, set changed_o.
  - k+=1. If k = num_clusters, go DONE; else go OLD_ADDR.
- DONE: done_o=1 for one cycle; go IDLE.

Boundary conditions:
- num_clusters_i=0: no accumulation into any slot; every point sets bad_id_o; no centroid writes; DONE follows the point scan.
- Per-cluster cost: 2+ACC_W+1 cycles (3 if empty).
- mem_we_o is asserted only in WRITE. All reads are side-effect free.
- Reset asserted mid-pass: immediate return to IDLE with no further writes. A partially updated centroid region is acceptable; the controller restarts the iteration.

Test Plan:
- Directed iteration: 3 points, num_clusters=2.
  - Points: 0x01000200 -> ID 0; 0x03000400 -> ID 0; 0x0A000000 -> ID 1. Cluster word 0x00010000.
  - Old centroids: 0, 0.
  - Required: writes 0x02000300 to FCENTROID_LADDR and 0x0A000000 to +1; changed_o=1; bad_id_o=0; one done_o pulse.
- Converged: rerun with old centroids equal to the computed means -> identical writes, changed_o=0.
- Truncation: points 0x00010001 and 0x00020002 in cluster 0 -> new centroid 0x00010001.
- Empty cluster: num_clusters=3, no point has ID 2, old centroid 2 = 0x12345678 -> rewritten 0x12345678; does not alone set changed_o.
- Bad ID: one point with ID 5 while num_clusters=2 -> bad_id_o=1, point excluded from all means, pass still completes.
- Reset mid-DIV, then start_i held high during a pass:
  - Reset mid-DIV: ready_o=1 and mem_we_o=0 immediately.
  - start_i high through a fresh pass: exactly one done_o, no second pass launched until IDLE.
